// File: rtl/sram_like_axi_bridge.sv
// Purpose : bridges an instruction and a data sram-like master onto one AXI master port, one transaction at a time.
// Latency : addr_ok in cycle N, data_ok no earlier than N+2 (AXI address phase, then response phase).
// Backpress: addr_ok is only given while idle; AXI valids hold their payload until the slave accepts.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   inst_* / data_*            sram-like request (req/wr/size/addr/wdata) and response (addr_ok/data_ok/rdata)
//   ar* / r*                   AXI read address / read data channels
//   aw* / w* / b*              AXI write address / write data / write response channels
//   Fixed AXI fields (len, burst, lock, cache, prot, awid, wid, wlast) are tied off by the instantiating level.
module sram_like_axi_bridge #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    // instruction master
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data master
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        sel_data_q, sel_data_d;   // 1: transaction belongs to the data master
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    // Instruction writes are issued as reads, so the instruction write controls are never consumed.
    logic unused_inst_wr_bits;
    assign unused_inst_wr_bits = ^{inst_wr, inst_wdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sel_data_q <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_data_q <= sel_data_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_data_d   = sel_data_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Data master wins ties. No handshake is offered while reset is
                // high so nothing gets accepted and then silently dropped.
                data_addr_ok = data_req & ~reset;
                inst_addr_ok = inst_req & ~data_req & ~reset;
                if (data_addr_ok) begin
                    sel_data_d = 1'b1;
                    size_d     = data_size;
                    addr_d     = data_addr;
                    wdata_d    = data_wdata;
                    state_d    = data_wr ? S_WR_REQ : S_RD_ADDR;
                end else if (inst_addr_ok) begin
                    sel_data_d = 1'b0;
                    size_d     = inst_size;
                    addr_d     = inst_addr;
                    state_d    = S_RD_ADDR;
                end
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    inst_data_ok = ~sel_data_q & ~reset;
                    data_data_ok = sel_data_q & ~reset;
                    state_d      = S_IDLE;
                end
            end
            S_WR_REQ: begin
                // Address and data channels complete independently; each valid
                // drops once its own handshake is done.
                awvalid   = ~aw_done_q;
                wvalid    = ~w_done_q;
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    state_d   = S_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_data_ok = ~reset;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte lanes follow the little-endian position of the access inside the word.
    always_comb begin
        unique case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = 4'b0011 << {addr_q[1], 1'b0};
            default: wstrb = 4'b1111;
        endcase
    end

    assign arid       = sel_data_q ? ID_DATA : ID_INST;
    assign araddr     = addr_q;
    assign arsize     = {1'b0, size_q};
    assign awaddr     = addr_q;
    assign awsize     = {1'b0, size_q};
    assign wdata      = wdata_q;
    assign inst_rdata = rdata;
    assign data_rdata = rdata;

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Purpose : self-checking bench for sram_like_axi_bridge; bench drives both masters and the AXI slave.
// Latency : n/a.
// Backpress: slave ready/valid signals are driven by directed sequences, then randomly.
module tb_sram_like_axi_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic        bvalid, bready;

    sram_like_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level model: one outstanding request and which AXI phases are finished.
    bit          m_busy = 1'b0;
    bit          m_data, m_wr, m_ar, m_aw, m_w;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    int          n_rd = 0;
    int          n_wr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Bytes touched by an access: 2**size bytes (4 for size 3), aligned down to that width.
    function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [31:0] addr);
        int n, base;
        logic [3:0] s;
        n    = (size == 2'd3) ? 4 : (1 << size);
        base = (int'(addr[1:0]) / n) * n;
        for (int b = 0; b < 4; b++) s[b] = (b >= base) && (b < base + n);
        return s;
    endfunction

    // Compare every DUT output against the model at the negedge, advance the model,
    // then return just after the next posedge so the caller can drive new inputs.
    task automatic tick();
        bit e_iaok, e_daok, e_arv, e_rr, e_awv, e_wv, e_br, e_idok, e_ddok;
        @(negedge clk);
        e_iaok = !reset && !m_busy && inst_req && !data_req;
        e_daok = !reset && !m_busy && data_req;
        e_arv  = m_busy && !m_wr && !m_ar;
        e_rr   = m_busy && !m_wr && m_ar;
        e_awv  = m_busy && m_wr && !m_aw;
        e_wv   = m_busy && m_wr && !m_w;
        e_br   = m_busy && m_wr && m_aw && m_w;
        e_idok = !reset && e_rr && rvalid && !m_data;
        e_ddok = !reset && ((e_rr && rvalid && m_data) || (e_br && bvalid));
        chk("inst_addr_ok", inst_addr_ok, e_iaok);
        chk("data_addr_ok", data_addr_ok, e_daok);
        chk("arvalid", arvalid, e_arv);
        chk("rready", rready, e_rr);
        chk("awvalid", awvalid, e_awv);
        chk("wvalid", wvalid, e_wv);
        chk("bready", bready, e_br);
        chk("inst_data_ok", inst_data_ok, e_idok);
        chk("data_data_ok", data_data_ok, e_ddok);
        if (e_arv) begin
            chk("araddr", araddr, m_addr);
            chk("arid", arid, m_data ? 32'd1 : 32'd0);
            chk("arsize", arsize, {30'd0, m_size});
        end
        if (e_awv) begin
            chk("awaddr", awaddr, m_addr);
            chk("awsize", awsize, {30'd0, m_size});
        end
        if (e_wv) begin
            chk("wdata", wdata, m_wdata);
            chk("wstrb", wstrb, exp_strb(m_size, m_addr));
        end
        if (e_idok) chk("inst_rdata", inst_rdata, rdata);
        if (e_ddok && !m_wr) chk("data_rdata", data_rdata, rdata);

        if (reset) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (data_req || inst_req) begin
                m_busy = 1'b1;
                m_data = data_req;
                m_wr   = data_req && data_wr;
                m_size = data_req ? data_size : inst_size;
                m_addr = data_req ? data_addr : inst_addr;
                m_wdata = data_wdata;
                m_ar = 1'b0; m_aw = 1'b0; m_w = 1'b0;
            end
        end else if (!m_wr) begin
            if (!m_ar) m_ar = arready;
            else if (rvalid) begin m_busy = 1'b0; n_rd++; end
        end else begin
            if (m_aw && m_w) begin
                if (bvalid) begin m_busy = 1'b0; n_wr++; end
            end else begin
                m_aw = m_aw | awready;
                m_w  = m_w | wready;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        reset = 1'b0;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'd0; inst_wdata = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic do_store(input string name, input logic [1:0] size, input logic [31:0] addr,
                            input logic [3:0] strb);
        data_req = 1'b1; data_wr = 1'b1; data_size = size; data_addr = addr; data_wdata = 32'hCAFE_F00D;
        tick();
        data_req = 1'b0; awready = 1'b1; wready = 1'b1;
        #1 chk(name, wstrb, {28'd0, strb});
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1 chk({name, "_ok"}, data_data_ok, 1);
        tick();
        quiet();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 1000000", $time);
        $fatal(1);
    end

    initial begin
        quiet();
        reset = 1'b1;
        @(posedge clk); #1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        tick();

        // Instruction fetch with a 3-cycle read response delay.
        inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC0_0000; arready = 1'b1;
        #1 chk("i30_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 1'b0;
        #1 chk("i30_arid", arid, 0);
        chk("i30_arsize", arsize, 2);
        chk("i30_araddr", araddr, 32'hBFC0_0000);
        tick();
        arready = 1'b0;
        tick();
        tick();
        rvalid = 1'b1; rdata = 32'h3C1D_0000;
        #1 chk("i30_data_ok", inst_data_ok, 1);
        chk("i30_rdata", inst_rdata, 32'h3C1D_0000);
        tick();
        rvalid = 1'b0;
        #1 chk("i30_pulse", inst_data_ok, 0);
        tick();

        // Simultaneous requests: data first, instruction right after data_ok.
        data_req = 1'b1; data_size = 2'd2; data_addr = 32'h8000_1004;
        inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC0_0010; arready = 1'b1;
        #1 chk("p31_data_aok", data_addr_ok, 1);
        chk("p31_inst_aok", inst_addr_ok, 0);
        tick();
        data_req = 1'b0;
        #1 chk("p31_arid", arid, 1);
        chk("p31_wait_aok", inst_addr_ok, 0);
        tick();
        rvalid = 1'b1; rdata = 32'h1122_3344;
        #1 chk("p31_data_ok", data_data_ok, 1);
        chk("p31_no_inst_ok", inst_data_ok, 0);
        tick();
        rvalid = 1'b0;
        #1 chk("p31_inst_aok_after", inst_addr_ok, 1);
        tick();
        inst_req = 1'b0;
        #1 chk("p31_inst_arid", arid, 0);
        tick();
        rvalid = 1'b1;
        tick();
        quiet();
        tick();

        // Byte store, address channel accepted before data channel.
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AB;
        tick();
        data_req = 1'b0; awready = 1'b1;
        #1 chk("s32_wstrb", wstrb, 4'b1000);
        chk("s32_awsize", awsize, 0);
        chk("s32_wdata", wdata, 32'hAB);
        tick();
        awready = 1'b0;
        #1 chk("s32_aw_dropped", awvalid, 0);
        chk("s32_w_held", wvalid, 1);
        tick();
        wready = 1'b1;
        tick();
        wready = 1'b0;
        #1 chk("s32_bready", bready, 1);
        tick();
        bvalid = 1'b1;
        #1 chk("s32_data_ok", data_data_ok, 1);
        tick();
        quiet();
        tick();

        do_store("s33_half", 2'd1, 32'h8000_0002, 4'b1100);
        do_store("s33_word", 2'd2, 32'h8000_0000, 4'b1111);
        do_store("s33_byte1", 2'd0, 32'h8000_0001, 4'b0010);
        do_store("s33_size3", 2'd3, 32'h8000_0004, 4'b1111);

        // Reset while waiting for read data abandons the transaction.
        data_req = 1'b1; data_size = 2'd2; data_addr = 32'h8000_2000; arready = 1'b1;
        tick();
        data_req = 1'b0;
        tick();
        arready = 1'b0; reset = 1'b1;
        #1 chk("r34_rready_before", rready, 1);
        tick();
        reset = 1'b0; rvalid = 1'b1;
        #1 chk("r34_rready", rready, 0);
        chk("r34_no_ok", {inst_data_ok, data_data_ok}, 0);
        tick();
        quiet();
        tick();

        // Stalled read address channel keeps its payload stable.
        inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC0_0100;
        tick();
        for (int i = 0; i < 10; i++) begin
            inst_req = 1'b1; inst_addr = $urandom;
            data_req = 1'b1; data_addr = $urandom; data_wr = 1'($urandom_range(0, 1));
            #1 chk("a35_arvalid", arvalid, 1);
            chk("a35_araddr", araddr, 32'hBFC0_0100);
            chk("a35_arid", arid, 0);
            chk("a35_aok", {inst_addr_ok, data_addr_ok}, 0);
            tick();
        end
        quiet(); arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1;
        tick();
        quiet();
        tick();

        // Random traffic on both masters and the AXI slave, with occasional reset.
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            inst_req   = ($urandom_range(0, 2) == 0);
            inst_wr    = 1'($urandom_range(0, 1));
            inst_size  = 2'($urandom);
            inst_addr  = $urandom;
            inst_wdata = $urandom;
            data_req   = ($urandom_range(0, 2) == 0);
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
            arready    = 1'($urandom_range(0, 1));
            rvalid     = ($urandom_range(0, 2) == 0);
            rdata      = $urandom;
            awready    = 1'($urandom_range(0, 1));
            wready     = 1'($urandom_range(0, 1));
            bvalid     = ($urandom_range(0, 2) == 0);
            tick();
        end
        chk("reads_completed", n_rd > 20, 1);
        chk("writes_completed", n_wr > 20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
